// File: rtl/conv_stream_loader.sv
// Splits one layer stream into a layer-parameter word and weight/kernel buffer writes.
// Defining CONV_STREAM_LOADER_STALLCNT_EN adds the stall_cnt output.
module conv_stream_loader #(
  parameter int DATA_WIDTH  = 64,
  parameter int B_DSHAPE    = 48,
  parameter int B_LAYERPARA = 96,
  parameter int B_CNT       = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [B_LAYERPARA-1:0] layer_para,
  output logic                   layer_para_we,
  output logic                   wb_clr,
  output logic                   kb_clr,
  output logic                   wb_we,
  output logic                   kb_we,
  output logic [DATA_WIDTH-1:0]  di
`ifdef CONV_STREAM_LOADER_STALLCNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_SETUP = 3'd3;
  localparam logic [2:0] S_LDWB  = 3'd4;
  localparam logic [2:0] S_LDKB  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [B_CNT-1:0] CNT_ONE = B_CNT'(1);

  logic [2:0]             state_q, state_d;
  logic [B_DSHAPE-1:0]    wb_ds_q, wb_ds_d;
  logic [B_DSHAPE-1:0]    kb_ds_q, kb_ds_d;
  logic [B_CNT-1:0]       wb_cnt_q, wb_cnt_d;
  logic [B_CNT-1:0]       kb_cnt_q, kb_cnt_d;
  logic [B_CNT-1:0]       rem_q, rem_d;
  logic                   term_q, term_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [B_LAYERPARA-1:0] para_q, para_d;
  logic                   pwe_q, pwe_d;
  logic                   clr_q, clr_d;
  logic                   wbwe_q, wbwe_d;
  logic                   kbwe_q, kbwe_d;
  logic [DATA_WIDTH-1:0]  di_q, di_d;

  logic                   accept;
  logic                   rem_one;
  logic                   hdr_zero;
  logic [B_DSHAPE-1:0]    hdr_ds;
  logic [B_CNT-1:0]       hdr_cnt;

  always_comb begin
    s_ready = 1'b0;
    unique case (1'b1)
      state_q == S_HDR0: s_ready = 1'b1;
      state_q == S_HDR1: s_ready = 1'b1;
      state_q == S_LDWB: s_ready = 1'b1;
      state_q == S_LDKB: s_ready = 1'b1;
      default:           s_ready = 1'b0;
    endcase
  end

  assign accept   = s_valid && s_ready;
  assign rem_one  = rem_q == CNT_ONE;
  assign hdr_ds   = s_data[B_DSHAPE-1:0];
  assign hdr_cnt  = s_data[B_DSHAPE +: B_CNT];
  assign hdr_zero = (wb_cnt_q == '0) && (hdr_cnt == '0);

  always_comb begin
    state_d  = state_q;
    wb_ds_d  = wb_ds_q;
    kb_ds_d  = kb_ds_q;
    wb_cnt_d = wb_cnt_q;
    kb_cnt_d = kb_cnt_q;
    rem_d    = rem_q;
    term_d   = term_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    para_d   = para_q;
    pwe_d    = 1'b0;
    clr_d    = 1'b0;
    wbwe_d   = 1'b0;
    kbwe_d   = 1'b0;
    di_d     = di_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_HDR0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      S_HDR0: begin
        if (accept) begin
          wb_ds_d  = hdr_ds;
          wb_cnt_d = hdr_cnt;
          if (s_last) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_HDR1;
          end
        end
      end
      S_HDR1: begin
        if (accept) begin
          kb_ds_d  = hdr_ds;
          kb_cnt_d = hdr_cnt;
          state_d  = S_SETUP;
          // an empty layer must end on word1; a non-empty one must not
          term_d   = s_last || hdr_zero;
          if (s_last != hdr_zero) err_d = 1'b1;
        end
      end
      S_SETUP: begin
        pwe_d  = 1'b1;
        clr_d  = 1'b1;
        para_d = {kb_ds_q, wb_ds_q};
        if (term_q) begin
          state_d = S_DONE;
        end else if (wb_cnt_q != '0) begin
          state_d = S_LDWB;
          rem_d   = wb_cnt_q;
        end else if (kb_cnt_q != '0) begin
          state_d = S_LDKB;
          rem_d   = kb_cnt_q;
        end else begin
          state_d = S_DONE;
        end
      end
      S_LDWB: begin
        if (accept) begin
          wbwe_d = 1'b1;
          di_d   = s_data;
          rem_d  = rem_q - CNT_ONE;
          if (rem_one && kb_cnt_q != '0) begin
            if (s_last) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_LDKB;
              rem_d   = kb_cnt_q;
            end
          end else if (rem_one) begin
            if (!s_last) err_d = 1'b1;
            state_d = S_DONE;
          end else if (s_last) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_LDKB: begin
        if (accept) begin
          kbwe_d = 1'b1;
          di_d   = s_data;
          rem_d  = rem_q - CNT_ONE;
          if (rem_one) begin
            if (!s_last) err_d = 1'b1;
            state_d = S_DONE;
          end else if (s_last) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      wb_ds_q  <= '0;
      kb_ds_q  <= '0;
      wb_cnt_q <= '0;
      kb_cnt_q <= '0;
      rem_q    <= '0;
      term_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      para_q   <= '0;
      pwe_q    <= 1'b0;
      clr_q    <= 1'b0;
      wbwe_q   <= 1'b0;
      kbwe_q   <= 1'b0;
      di_q     <= '0;
    end else begin
      state_q  <= state_d;
      wb_ds_q  <= wb_ds_d;
      kb_ds_q  <= kb_ds_d;
      wb_cnt_q <= wb_cnt_d;
      kb_cnt_q <= kb_cnt_d;
      rem_q    <= rem_d;
      term_q   <= term_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      para_q   <= para_d;
      pwe_q    <= pwe_d;
      clr_q    <= clr_d;
      wbwe_q   <= wbwe_d;
      kbwe_q   <= kbwe_d;
      di_q     <= di_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign layer_para    = para_q;
  assign layer_para_we = pwe_q;
  assign wb_clr        = clr_q;
  assign kb_clr        = clr_q;
  assign wb_we         = wbwe_q;
  assign kb_we         = kbwe_q;
  assign di            = di_q;

`ifdef CONV_STREAM_LOADER_STALLCNT_EN
  logic [31:0] stall_q;

  // s_ready is high exactly in the states where a missing beat is a stall
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
    end else if (s_ready && !s_valid && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_stream_loader.sv
// Bench for conv_stream_loader: directed and random layers against a stream-level model.
// Build with CONV_STREAM_LOADER_STALLCNT_EN to also check stall_cnt.
module tb_conv_stream_loader;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [95:0] layer_para;
  logic        layer_para_we;
  logic        wb_clr;
  logic        kb_clr;
  logic        wb_we;
  logic        kb_we;
  logic [63:0] di;
`ifdef CONV_STREAM_LOADER_STALLCNT_EN
  logic [31:0] stall_cnt;
`endif

  conv_stream_loader dut (
    .clk           (clk),
    .rstn          (rstn),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_last        (s_last),
    .s_ready       (s_ready),
    .layer_para    (layer_para),
    .layer_para_we (layer_para_we),
    .wb_clr        (wb_clr),
    .kb_clr        (kb_clr),
    .wb_we         (wb_we),
    .kb_we         (kb_we),
    .di            (di)
`ifdef CONV_STREAM_LOADER_STALLCNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] beat_d[$];
  bit          beat_l[$];
  logic [64:0] exp_w[$];
  logic [64:0] obs_w[$];

  bit          exp_err;
  bit          exp_pwe;
  logic [95:0] exp_para;
  int          exp_cons;
  int          exp_tot;

  bit          done_seen;
  int          done_cyc;
  int          done_cnt;
  int          para_cnt;
  logic [95:0] para_val;
  int          start_cyc;
  int          k;
  int          stall_exp;

  int r_wc, r_kc, r_tot, r_f, r_la, r_ex;
  bit r_bub;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wb_we === 1'b1) obs_w.push_back({1'b0, di});
    if (kb_we === 1'b1) obs_w.push_back({1'b1, di});
    if (wb_we === 1'b1 || kb_we === 1'b1)
      chk("we_excl", {wb_we, kb_we} == 2'b11, 0);
    if (layer_para_we === 1'b1 || wb_clr === 1'b1 || kb_clr === 1'b1)
      chk("clr_sync", {layer_para_we, wb_clr, kb_clr}, 3'b111);
    if (layer_para_we === 1'b1) begin
      para_cnt++;
      para_val = layer_para;
    end
    if (done === 1'b1) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
      done_cnt++;
      chk("busy_at_done", busy, 0);
    end
  end

  task automatic make_layer(input logic [47:0] wd, input logic [15:0] wc,
                            input logic [47:0] kd, input logic [15:0] kc,
                            input int last_at, input int extra,
                            input bit seqd, input int cap);
    int n;
    logic [63:0] w;
    beat_d.delete();
    beat_l.delete();
    n = 2 + int'(wc) + int'(kc) + extra;
    if (n > cap) n = cap;
    for (int i = 0; i < n; i++) begin
      if (i == 0) w = {wc, wd};
      else if (i == 1) w = {kc, kd};
      else if (seqd) w = 64'(i - 1);
      else w = {$urandom, $urandom};
      beat_d.push_back(w);
      beat_l.push_back(i == last_at);
    end
  endtask

  // Walks the beat list with the layer rules; no knowledge of DUT states.
  task automatic model();
    logic [63:0] h0, h1;
    int wc, kc;
    exp_w.delete();
    exp_err  = 0;
    exp_pwe  = 0;
    exp_para = '0;
    h0 = beat_d[0];
    h1 = beat_d[1];
    wc = int'(h0[63:48]);
    kc = int'(h1[63:48]);
    exp_tot = wc + kc;
    exp_cons = 1;
    if (beat_l[0]) begin
      exp_err = 1;
      return;
    end
    exp_pwe  = 1;
    exp_para = {h1[47:0], h0[47:0]};
    exp_cons = 2;
    if (beat_l[1]) begin
      exp_err = (exp_tot != 0);
      return;
    end
    if (exp_tot == 0) begin
      exp_err = 1;
      return;
    end
    for (int i = 0; i < exp_tot; i++) begin
      exp_w.push_back({(i >= wc), beat_d[2+i]});
      exp_cons = 3 + i;
      if (i == exp_tot - 1) begin
        if (!beat_l[2+i]) exp_err = 1;
      end else if (beat_l[2+i]) begin
        exp_err = 1;
        break;
      end
    end
  endtask

  task automatic do_start();
    obs_w.delete();
    para_cnt  = 0;
    done_cnt  = 0;
    done_seen = 0;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic stream(input bit bub, input int stop_k);
    bit acc, tog, setup_it, vnow;
    k = 0;
    tog = 0;
    setup_it = 0;
    stall_exp = 0;
    for (int g = 0; g < 400 && !done_seen; g++) begin
      if (stop_k > 0 && k == stop_k) break;
      tog = ~tog;
      vnow = (k < beat_d.size()) && (!bub || !tog);
      s_valid = vnow;
      s_data  = vnow ? beat_d[k] : {$urandom, $urandom};
      s_last  = vnow ? beat_l[k] : 1'($urandom);
      if (!vnow && k < exp_cons && !setup_it) stall_exp++;
      @(negedge clk);
      if (g == 0) begin
        chk("busy_on", busy, 1);
        chk("err_clr", err, 0);
      end
      acc = s_valid && s_ready;
      @(posedge clk);
      #1;
      setup_it = acc && (k == 1);
      if (acc) k++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_layer(input bit lat);
    chk("done", done_seen, 1);
    chk("done_pulses", done_cnt, 1);
    chk("n_writes", obs_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++)
      if (i < obs_w.size()) chk("write", obs_w[i], exp_w[i]);
    chk("para_we", para_cnt, exp_pwe);
    if (exp_pwe) chk("layer_para", para_val, exp_para);
    chk("err", err, exp_err);
    chk("consumed", k, exp_cons);
    chk("busy_off", busy, 0);
    if (lat) chk("latency", done_cyc - start_cyc, exp_tot + 5);
`ifdef CONV_STREAM_LOADER_STALLCNT_EN
    chk("stall_cnt", stall_cnt, stall_exp);
`endif
  endtask

  task automatic run_layer(input bit bub);
    model();
    do_start();
    stream(bub, 0);
    check_layer(!bub && !exp_err && exp_pwe);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rstn    = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_strobes",
        {layer_para_we, wb_clr, kb_clr, wb_we, kb_we}, 0);
    chk("rst_data", {layer_para, di}, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // nominal layer, continuous valid
    make_layer(48'h000300050004, 16'd5, 48'h000300030004, 16'd3,
               9, 0, 1, 100);
    model();
    do_start();
    stream(0, 0);
    check_layer(1);
    chk("nom_para", para_val, 96'h000300030004_000300050004);
    chk("nom_lat", done_cyc - start_cyc, 13);
    repeat (2) @(posedge clk);
    #1;

    // same layer with alternating bubbles
    run_layer(1);

    // zero weight section
    make_layer(48'h1234, 16'd0, 48'h5678, 16'd2, 3, 0, 0, 100);
    run_layer(0);

    // header-only layer
    make_layer(48'h1, 16'd0, 48'h2, 16'd0, 1, 0, 0, 100);
    run_layer(0);
    chk("empty_lat", done_cyc - start_cyc, 5);

    // early last on third weight beat
    make_layer(48'h000300050004, 16'd5, 48'h000300030004, 16'd3,
               4, 0, 1, 100);
    run_layer(0);

    // missing last on final kernel beat, one excess beat
    make_layer(48'hAAAA, 16'd2, 48'hBBBB, 16'd2, -1, 1, 0, 100);
    run_layer(0);
    s_valid = 1'b1;
    s_data  = beat_d[k];
    s_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("excess_ready", s_ready, 0);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;

    // maximum weight count, early last keeps it short
    make_layer(48'hCAFE, 16'hFFFF, 48'hBEEF, 16'd3, 4, 0, 0, 7);
    run_layer(0);

    // reset after two weight beats
    make_layer(48'h000300050004, 16'd5, 48'h000300030004, 16'd3,
               9, 0, 0, 100);
    model();
    do_start();
    stream(0, 4);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_we", {wb_we, kb_we}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_para_we", layer_para_we, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    run_layer(0);

    // random layers with random faults
    for (int r = 0; r < 10; r++) begin
      r_wc  = $urandom_range(0, 4);
      r_kc  = $urandom_range(0, 4);
      r_tot = r_wc + r_kc;
      r_f   = $urandom_range(0, 3);
      r_ex  = 0;
      r_la  = 1 + r_tot;
      r_bub = 1'($urandom);
      if (r_f == 1 && r_tot >= 2) begin
        r_la = 2 + $urandom_range(0, r_tot - 2);
      end else if (r_f == 2) begin
        r_la = -1;
        r_ex = 1;
      end else if (r_f == 3) begin
        r_la = 0;
      end
      make_layer(48'({$urandom, $urandom}), 16'(r_wc),
                 48'({$urandom, $urandom}), 16'(r_kc),
                 r_la, r_ex, 0, 100);
      run_layer(r_bub);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
